// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampled, 2-FF synced rx) feeding a FWFT byte FIFO; push ~2+9.5*16*DIV clk after start edge.
// No backpressure on the line: a byte arriving while the FIFO is full (and not being popped) is dropped and flagged as overrun.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          framing_err,
    output logic                          busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

    state_t          state;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            stop_smp;
    logic            push_vld;
    logic            ferr_set;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            ovr_set;

    // Preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    assign tick = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         div_cnt <= '0;
        else if (state == S_IDLE || tick)  div_cnt <= '0;
        else                               div_cnt <= div_cnt + DW'(1);
    end

    assign stop_smp = (state == S_STOP) && tick && (tick_cnt == 4'd15);
    assign push_vld = stop_smp && rx_s;
    assign ferr_set = stop_smp && !rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                S_IDLE: if (!rx_s) begin
                    state    <= S_START;
                    busy     <= 1'b1;
                    tick_cnt <= '0;
                end
                S_START: if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                S_DATA: if (tick) begin
                    if (tick_cnt == 4'd15) begin
                        tick_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                S_STOP: if (tick) begin
                    if (tick_cnt == 4'd15) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_BRK;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                // Stay here while the line is held low so a break cannot retrigger a frame.
                S_BRK: if (rx_s) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && (cnt != '0);
    assign do_push = push_vld && (!full || do_pop);
    assign ovr_set = push_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (ferr_set)     framing_err <= 1'b1;
            else if (clr_err) framing_err <= 1'b0;
        end
    end

    assign rx_valid   = (cnt != '0);
    assign fifo_count = cnt;
    assign rd_data    = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DIV=1 (16 clk per bit) with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       framing_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
        .overrun(overrun), .framing_err(framing_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every accepted pop must match the oldest byte the stimulus expects.
    always @(negedge clk) begin
        if (!reset && rd_en && rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte", rd_data);
            end else begin
                check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // One 160-clk frame; cycle 0 is the start-bit edge. rd_en is pulsed at pop_at, reset at rst_at.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pop_at, input int rst_at);
        for (int c = 0; c < 160; c++) begin
            @(posedge clk); #1;
            if (c < 16)       rx = 1'b0;
            else if (c < 144) rx = d[(c - 16) / 16];
            else              rx = stop_b;
            rd_en = (c == pop_at);
            if (c == rst_at) begin
                reset = 1'b1;
                exp_q.delete();
                #1;
                check("rst_busy", busy, 0);
                check("rst_rx_valid", rx_valid, 0);
                check("rst_count", fifo_count, 0);
                check("rst_rd_data", rd_data, 0);
                check("rst_overrun", overrun, 0);
                check("rst_framing", framing_err, 0);
            end
            if (c == rst_at + 3) reset = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        rd_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        send_frame(d, 1'b1, -1, -1);
        idle(4);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_rd_data", rd_data, 0);
        check("init_rx_valid", rx_valid, 0);
        check("init_count", fifo_count, 0);
        check("init_overrun", overrun, 0);
        check("init_framing", framing_err, 0);
        check("init_busy", busy, 0);
        reset = 1'b0;
        idle(20);

        // Single byte
        send_byte(8'hA5, 1);
        check("single_valid", rx_valid, 1);
        check("single_data", rd_data, 8'hA5);
        check("single_count", fifo_count, 1);
        check("single_busy", busy, 0);
        pop();
        check("single_valid_after_pop", rx_valid, 0);
        check("single_count_after_pop", fifo_count, 0);

        // Burst past capacity
        for (int i = 1; i <= 5; i++) send_byte(8'(i), i <= DEPTH);
        check("burst_count", fifo_count, 4);
        check("burst_overrun", overrun, 1);
        check("burst_framing", framing_err, 0);
        repeat (4) pop();
        check("burst_drained", rx_valid, 0);
        clear_flags();
        check("burst_overrun_cleared", overrun, 0);

        // Pop lands on the push edge of the fifth byte into a full FIFO
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
        exp_q.push_back(8'h05);
        send_frame(8'h05, 1'b1, 154, -1);
        idle(4);
        check("simul_overrun", overrun, 0);
        check("simul_count", fifo_count, 4);
        repeat (4) pop();
        check("simul_drained", fifo_count, 0);

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, -1, -1);
        repeat (40) begin @(posedge clk); #1; end
        check("ferr_flag", framing_err, 1);
        check("ferr_count", fifo_count, 0);
        check("ferr_busy_low_line", busy, 1);
        idle(10);
        check("ferr_busy_released", busy, 0);
        clear_flags();
        check("ferr_cleared", framing_err, 0);
        send_byte(8'h55, 1);
        check("after_ferr_count", fifo_count, 1);
        pop();
        check("after_ferr_drained", fifo_count, 0);

        // Short glitch on the line
        rx = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        idle(40);
        check("glitch_count", fifo_count, 0);
        check("glitch_busy", busy, 0);
        check("glitch_framing", framing_err, 0);
        check("glitch_overrun", overrun, 0);

        // Reset during bit 3 with a byte already queued
        send_byte(8'h11, 1);
        check("pre_rst_count", fifo_count, 1);
        send_frame(8'hFF, 1'b1, -1, 70);
        idle(20);
        check("post_rst_count", fifo_count, 0);
        check("post_rst_busy", busy, 0);
        send_byte(8'h81, 1);
        check("post_rst_one_byte", fifo_count, 1);
        pop();
        check("post_rst_drained", fifo_count, 0);

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
